// File: rtl/ysyx_fetch_pc_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handoff
// and the redirect inputs from decode/CSR logic. master = fetch unit side.
interface ysyx_fetch_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            is_ecall;
    logic [XLEN-1:0] mtvecdata;
    logic            is_mret;
    logic [XLEN-1:0] mepcdata;
    logic            jump_en;
    logic [XLEN-1:0] jump_target;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  is_ecall, mtvecdata, is_mret, mepcdata, jump_en, jump_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output is_ecall, mtvecdata, is_mret, mepcdata, jump_en, jump_target
    );
endinterface

// File: rtl/ysyx_fetch_pc_unit.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time and hands
// the instruction to decode, redirecting on ecall / mret / jump.
module ysyx_fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_fetch_pc_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] inst_reg;
    logic [XLEN-1:0] inst_pc_reg;
    logic            pend_valid_reg;
    logic [XLEN-1:0] pend_target_reg;

    logic            redir_now;
    logic            redir_any;
    logic [XLEN-1:0] redir_target_now;
    logic [XLEN-1:0] take_target;
    logic [XLEN-1:0] pc_inc;

    // Trap beats return beats jump; targets are always word aligned.
    always_comb begin
        redir_target_now = bus.jump_target;
        if (bus.is_ecall) begin
            redir_target_now = bus.mtvecdata;
        end else if (bus.is_mret) begin
            redir_target_now = bus.mepcdata;
        end
        redir_target_now[1:0] = 2'b00;
    end

    assign redir_now   = bus.is_ecall | bus.is_mret | bus.jump_en;
    assign redir_any   = redir_now | pend_valid_reg;
    // A redirect raised this cycle is newer than anything parked in pending.
    assign take_target = redir_now ? redir_target_now : pend_target_reg;
    assign pc_inc      = pc_reg + XLEN'(4);

    assign bus.imem_req_valid = (state_reg == ST_REQ) && !redir_any;
    assign bus.imem_req_addr  = pc_reg;
    assign bus.inst_valid     = (state_reg == ST_HOLD) && !redir_now;
    assign bus.inst           = inst_reg;
    assign bus.inst_pc        = inst_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            inst_reg        <= '0;
            inst_pc_reg     <= RESET_PC;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_REQ;
                end
                ST_REQ: begin
                    if (redir_any) begin
                        pc_reg         <= take_target;
                        pend_valid_reg <= 1'b0;
                    end else if (bus.imem_req_ready) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The in-flight response can't be cancelled, so a redirect
                    // waits here until it arrives and is then thrown away.
                    if (bus.imem_rsp_valid) begin
                        if (redir_any) begin
                            pc_reg         <= take_target;
                            pend_valid_reg <= 1'b0;
                            state_reg      <= ST_REQ;
                        end else begin
                            inst_reg    <= bus.imem_rsp_data;
                            inst_pc_reg <= pc_reg;
                            state_reg   <= ST_HOLD;
                        end
                    end else if (redir_now) begin
                        pend_valid_reg  <= 1'b1;
                        pend_target_reg <= redir_target_now;
                    end
                end
                ST_HOLD: begin
                    if (redir_now) begin
                        pc_reg    <= redir_target_now;
                        state_reg <= ST_REQ;
                    end else if (bus.inst_ready) begin
                        pc_reg    <= pc_inc;
                        state_reg <= ST_REQ;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_fetch_pc_unit.sv
// Bench for ysyx_fetch_pc_unit: directed scenarios plus a randomized run,
// both checked against a transaction-level model of fetch/redirect behaviour.
module tb_ysyx_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_fetch_pc_unit_if #(.XLEN(32)) bus ();

    ysyx_fetch_pc_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus knobs (percentages / delay range)
    int p_req_ready, p_inst_ready, p_redir_hold, p_redir_wait, p_spur;
    int min_delay, max_delay;
    bit mem_fixed;
    logic [31:0] mem_fixed_val;

    // One-shot forced redirect, applied in the next HOLD (or WAIT) cycle
    bit fr_en, fr_wait, fr_e, fr_m, fr_j;
    logic [31:0] fr_mtvec, fr_mepc, fr_jt;

    // Reference model: architectural next-fetch PC and the one transaction in flight
    logic [31:0] exp_pc, held_pc, held_inst, out_addr;
    bit held, outstanding, squash, idle;
    int rsp_cnt, cyc;

    // Observations
    int hs_count, first_valid_cyc, dead_seen, valid_seen;
    logic [31:0] last_hs_addr;
    logic last_iv;
    logic [31:0] cons_pc[$];
    int cons_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem_fixed) return mem_fixed_val;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(7) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
        return r;
    endfunction

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        bus.is_ecall = 1'b0; bus.is_mret = 1'b0; bus.jump_en = 1'b0;
        bus.mtvecdata = '0; bus.mepcdata = '0; bus.jump_target = '0;
        #1;
    endtask

    // Release just after a rising edge so the next step() lands in the IDLE cycle.
    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_pc = RESET_PC; held = 0; outstanding = 0; squash = 0; idle = 1;
        cyc = 0; first_valid_cyc = -1;
        cons_pc.delete(); cons_cyc.delete();
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_req_valid"},  32'(bus.imem_req_valid), 32'd0);
        chk({pfx, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
        chk({pfx, "_inst"},       bus.inst, 32'd0);
        chk({pfx, "_inst_pc"},    bus.inst_pc, RESET_PC);
    endtask

    task automatic step();
        logic do_rsp, redir;
        logic [2:0] sel;
        logic [31:0] tgt;
        bit exp_req, exp_iv;
        @(negedge clk);
        bus.imem_req_ready = (int'($urandom_range(99)) < p_req_ready);
        do_rsp = 1'b0;
        if (outstanding) begin
            if (rsp_cnt == 0) do_rsp = 1'b1;
            else rsp_cnt--;
        end
        bus.imem_rsp_valid = do_rsp || (!outstanding && int'($urandom_range(99)) < p_spur);
        bus.imem_rsp_data  = do_rsp ? memval(out_addr) : $urandom;
        bus.inst_ready     = (int'($urandom_range(99)) < p_inst_ready);
        bus.is_ecall = 1'b0; bus.is_mret = 1'b0; bus.jump_en = 1'b0;
        bus.mtvecdata = rand_tgt(); bus.mepcdata = rand_tgt(); bus.jump_target = rand_tgt();
        if ((held && int'($urandom_range(99)) < p_redir_hold) ||
            (outstanding && int'($urandom_range(99)) < p_redir_wait)) begin
            sel = 3'($urandom_range(7, 1));
            bus.is_ecall = sel[0]; bus.is_mret = sel[1]; bus.jump_en = sel[2];
        end
        if (fr_en && ((fr_wait && outstanding) || (!fr_wait && held))) begin
            bus.is_ecall = fr_e; bus.is_mret = fr_m; bus.jump_en = fr_j;
            bus.mtvecdata = fr_mtvec; bus.mepcdata = fr_mepc; bus.jump_target = fr_jt;
            fr_en = 0;
        end
        #1;
        redir = bus.is_ecall | bus.is_mret | bus.jump_en;
        if (bus.is_ecall)     tgt = bus.mtvecdata;
        else if (bus.is_mret) tgt = bus.mepcdata;
        else                  tgt = bus.jump_target;
        tgt = tgt & 32'hFFFF_FFFC;

        exp_req = !idle && !outstanding && !held;
        exp_iv  = held && !redir;
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", bus.imem_req_addr, exp_pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            chk("inst", bus.inst, held_inst);
            chk("inst_pc", bus.inst_pc, held_pc);
        end

        last_iv = bus.inst_valid;
        if (bus.inst_valid) begin
            valid_seen++;
            if (bus.inst == 32'hDEAD_BEEF) dead_seen++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            hs_count++;
            last_hs_addr = bus.imem_req_addr;
        end

        if (redir && !idle) begin
            exp_pc = tgt;
            if (outstanding) squash = 1;
            held = 0;
        end
        if (do_rsp) begin
            outstanding = 0;
            if (!squash) begin
                held = 1; held_pc = out_addr; held_inst = bus.imem_rsp_data;
            end
            squash = 0;
        end
        if (exp_iv && bus.inst_ready) begin
            cons_pc.push_back(bus.inst_pc);
            cons_cyc.push_back(cyc);
            exp_pc = held_pc + 32'd4;
            held = 0;
        end
        if (exp_req && bus.imem_req_ready) begin
            outstanding = 1;
            out_addr = exp_pc;
            rsp_cnt = int'($urandom_range(max_delay, min_delay));
        end
        idle = 0;
        cyc++;
    endtask

    // what: 0 = holding an instruction at pc, 1 = request in flight, 2 = handshake count reaches pc
    task automatic run_until(input string tag, input int what, input logic [31:0] pc);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if ((what == 0 && held && held_pc == pc) || (what == 1 && outstanding) ||
                (what == 2 && hs_count >= int'(pc)))
                hit = 1;
            else
                step();
        end
        chk({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic quiet_knobs();
        p_req_ready = 100; p_inst_ready = 100; p_redir_hold = 0; p_redir_wait = 0;
        p_spur = 0; min_delay = 0; max_delay = 0; mem_fixed = 0; fr_en = 0;
    endtask

    initial begin
        logic [31:0] snap_inst, snap_pc;
        int hs0;
        hs_count = 0; dead_seen = 0; valid_seen = 0; last_hs_addr = '0;
        quiet_knobs();

        // Power-on reset values
        assert_reset();
        repeat (2) @(negedge clk);
        chk_reset("por");
        release_reset();

        // Zero-wait memory returning addi x0,x0,0 everywhere; decode always ready
        mem_fixed = 1; mem_fixed_val = 32'h0000_0013;
        repeat (10) step();
        chk("t1_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
        chk("t1_cons_count", 32'(cons_pc.size()), 32'd3);
        if (cons_pc.size() >= 3) begin
            chk("t1_pc0", cons_pc[0], 32'h8000_0000);
            chk("t1_pc1", cons_pc[1], 32'h8000_0004);
            chk("t1_pc2", cons_pc[2], 32'h8000_0008);
            chk("t1_gap01", 32'(cons_cyc[1] - cons_cyc[0]), 32'd3);
            chk("t1_gap12", 32'(cons_cyc[2] - cons_cyc[1]), 32'd3);
        end
        chk("t1_inst", bus.inst, 32'h0000_0013);

        // Request stalled 5 cycles, then held instruction stalled 4 cycles
        assert_reset();
        release_reset();
        hs0 = hs_count;
        p_req_ready = 0; p_inst_ready = 0;
        repeat (6) step();
        chk("stall_no_hs", 32'(hs_count - hs0), 32'd0);
        p_req_ready = 100;
        run_until("stall_hold", 0, 32'h8000_0000);
        step();
        snap_inst = bus.inst; snap_pc = bus.inst_pc;
        repeat (4) step();
        chk("stall_hs_once", 32'(hs_count - hs0), 32'd1);
        chk("stall_addr", last_hs_addr, 32'h8000_0000);
        chk("hold_inst_stable", bus.inst, snap_inst);
        chk("hold_pc_stable", bus.inst_pc, 32'h8000_0000);
        chk("hold_still_valid", 32'(last_iv), 32'd1);

        // ecall in HOLD at 8000_0010
        assert_reset();
        release_reset();
        quiet_knobs();
        run_until("ecall_hold", 0, 32'h8000_0010);
        fr_en = 1; fr_wait = 0; fr_e = 1; fr_m = 0; fr_j = 0;
        fr_mtvec = 32'h8000_0100; fr_mepc = 32'h1234_5678; fr_jt = 32'h8765_4320;
        step();
        chk("ecall_squash", 32'(last_iv), 32'd0);
        run_until("ecall_hs", 2, 32'(hs_count + 1));
        chk("ecall_target", last_hs_addr, 32'h8000_0100);

        // mret + jump together: mret wins
        run_until("mret_hold", 0, 32'h8000_0100);
        fr_en = 1; fr_wait = 0; fr_e = 0; fr_m = 1; fr_j = 1;
        fr_mepc = 32'h8000_0014; fr_jt = 32'h8000_0200;
        step();
        run_until("mret_hs", 2, 32'(hs_count + 1));
        chk("mret_target", last_hs_addr, 32'h8000_0014);

        // ecall + mret together: mtvec wins, low bits cleared
        run_until("ecm_hold", 0, 32'h8000_0014);
        fr_en = 1; fr_wait = 0; fr_e = 1; fr_m = 1; fr_j = 0;
        fr_mtvec = 32'h8000_0183; fr_mepc = 32'h8000_0040;
        step();
        run_until("ecm_hs", 2, 32'(hs_count + 1));
        chk("ecm_target", last_hs_addr, 32'h8000_0180);

        // PC wrap from FFFF_FFFC to 0
        run_until("wrap_hold", 0, 32'h8000_0180);
        fr_en = 1; fr_wait = 0; fr_e = 0; fr_m = 0; fr_j = 1; fr_jt = 32'hFFFF_FFFC;
        step();
        run_until("wrap_top", 0, 32'hFFFF_FFFC);
        step();
        run_until("wrap_hs", 2, 32'(hs_count + 1));
        chk("wrap_addr", last_hs_addr, 32'h0000_0000);

        // Jump during WAIT: the DEADBEEF response must be dropped
        mem_fixed = 1; mem_fixed_val = 32'hDEAD_BEEF; min_delay = 2; max_delay = 2;
        dead_seen = 0;
        run_until("wait_out", 1, 32'd0);
        fr_en = 1; fr_wait = 1; fr_e = 0; fr_m = 0; fr_j = 1; fr_jt = 32'h8000_0300;
        run_until("wait_hs", 2, 32'(hs_count + 1));
        chk("wait_target", last_hs_addr, 32'h8000_0300);
        chk("wait_no_deadbeef", 32'(dead_seen), 32'd0);
        quiet_knobs();

        // Reset asserted in WAIT, then late responses after release
        run_until("rst_hold", 0, 32'h8000_0308);
        run_until("rst_out", 1, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        release_reset();
        valid_seen = 0;
        p_req_ready = 0; p_spur = 100;
        repeat (5) step();
        chk("late_rsp_ignored", 32'(valid_seen), 32'd0);
        quiet_knobs();

        // Randomized run against the model, with one reset in the middle
        p_req_ready = 60; p_inst_ready = 60; p_redir_hold = 20; p_redir_wait = 15;
        p_spur = 10; min_delay = 0; max_delay = 3;
        repeat (3000) step();
        assert_reset();
        release_reset();
        repeat (3000) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
